// File: rtl/brom_fetch_pkg.sv
// rtl/brom_fetch_pkg.sv - shared states, constants and line type for the boot ROM line fetcher
package brom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    RESP
  } brom_fetch_state_t;

  localparam int BROM_WORD_BYTES  = 4;
  localparam int BROM_LINE_OFFSET = 4;
  localparam int BROM_LINE_WORDS  = 4;

  typedef logic [32*BROM_LINE_WORDS-1:0] brom_line_t;

endpackage

// File: rtl/brom_line_fetch.sv
// rtl/brom_line_fetch.sv - line fetch initiator issuing sequential word reads to the boot ROM
// Optional per-word watchdog enabled by BROM_FETCH_TIMEOUT_EN.
module brom_line_fetch
  import brom_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_WIDTH-1:0]        req_addr_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [32*WORDS_PER_LINE-1:0] resp_line_o,
  output logic                         resp_error_o,
  output logic                         brom_req_valid_o,
  output logic [ADDR_WIDTH-1:0]        brom_req_address_o,
  input  logic                         brom_ready_i,
  input  logic [31:0]                  brom_resp_data_i,
  input  logic                         brom_resp_valid_i
);

  localparam int IDX_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((2 ** BROM_LINE_OFFSET) - 1);

  brom_fetch_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0]      index;
  logic [LINE_W-1:0]     line;
  logic                  error;
  logic                  timed_out;

`ifdef BROM_FETCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;

  // Held at zero outside WAIT_RESP so every word starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RESP) timer <= '0;
    else                           timer <= timer + 1'b1;
  end

  assign timed_out = (state == WAIT_RESP) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      index <= '0;
      line  <= '0;
      error <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            base  <= req_addr_i & ~LINE_MASK;
            index <= '0;
            line  <= '0;
            error <= 1'b0;
          end
        end
        WAIT_RESP: begin
          // A response landing on the limit cycle still wins over the watchdog.
          if (brom_resp_valid_i) begin
            line[32*index +: 32] <= brom_resp_data_i;
            if (index != LAST_IDX) index <= index + 1'b1;
          end else if (timed_out) begin
            line  <= '0;
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next       = state;
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    brom_req_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = ISSUE;
      end
      ISSUE: begin
        brom_req_valid_o = brom_ready_i;
        if (brom_ready_i) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (brom_resp_valid_i) state_next = (index == LAST_IDX) ? RESP : ISSUE;
        else if (timed_out)    state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign brom_req_address_o = base + (ADDR_WIDTH'(index) << $clog2(BROM_WORD_BYTES));
  assign resp_line_o        = line;
  assign resp_error_o       = (state == RESP) && error;

endmodule

// File: tb/tb_brom_line_fetch.sv
// tb/tb_brom_line_fetch.sv - directed self-checking bench for brom_line_fetch
module tb_brom_line_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [23:0]  req_addr_i;
  logic         resp_valid_o;
  logic         resp_ready_i;
  logic [127:0] resp_line_o;
  logic         resp_error_o;
  logic         brom_req_valid_o;
  logic [23:0]  brom_req_address_o;
  logic         brom_ready_i;
  logic [31:0]  brom_resp_data_i;
  logic         brom_resp_valid_i;

  int checks = 0;
  int errors = 0;

  logic [23:0]  issued [16];
  int           n_issue;
  int           lat;
  logic [127:0] got_line;
  logic         got_err;
  int           bad_valid;
  int           bp_bad;
  bit           hs;

  brom_line_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_line_o        (resp_line_o),
    .resp_error_o       (resp_error_o),
    .brom_req_valid_o   (brom_req_valid_o),
    .brom_req_address_o (brom_req_address_o),
    .brom_ready_i       (brom_ready_i),
    .brom_resp_data_i   (brom_resp_data_i),
    .brom_resp_valid_i  (brom_resp_valid_i)
  );

  always #5 clk = ~clk;

  // Drives one line request and plays the boot ROM responder; data returned = word address.
  // lat is counted in cycles with the acceptance cycle as cycle 0.
  task automatic run_line(input logic [23:0] addr, input int lat_norm, input int slow_idx,
                          input int slow_lat, input bit gate, input int bp,
                          input int abort_idx, input int budget);
    int cyc, pend, low, bp_left;
    bit abort_now;
    logic [31:0] pdata;
    n_issue = 0; lat = -1; bad_valid = 0; bp_bad = 0; got_line = '0; got_err = 1'b0; hs = 0;
    pend = 0; low = 0; bp_left = 0; abort_now = 0; pdata = '0;
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = addr; brom_ready_i = 1'b1; resp_ready_i = 1'b0;
    brom_resp_valid_i = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      req_valid_i = 1'b0;
      brom_resp_valid_i = 1'b0;
      if (hs) begin
        resp_ready_i = 1'b0;
        break;
      end
      if (rst) begin
        rst = 1'b0;
        break;
      end
      if (abort_now) begin
        rst = 1'b1;
        abort_now = 0;
        continue;
      end
      brom_ready_i = !(gate && low > 0);
      if (low > 0) low--;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          brom_resp_valid_i = 1'b1;
          brom_resp_data_i  = pdata;
          if (gate) low = 7;
        end
      end
      #1;
      if (brom_req_valid_o) begin
        if (!brom_ready_i) bad_valid++;
        if (n_issue < 16) issued[n_issue] = brom_req_address_o;
        pdata = {8'h00, brom_req_address_o};
        pend = (n_issue == slow_idx) ? slow_lat : lat_norm;
        if (n_issue == abort_idx) abort_now = 1;
        n_issue++;
      end
      if (resp_valid_o) begin
        if (lat < 0) begin
          lat = cyc; got_line = resp_line_o; got_err = resp_error_o; bp_left = bp;
        end else if (resp_line_o !== got_line || resp_error_o !== got_err ||
                     req_ready_o !== 1'b0 || brom_req_valid_o !== 1'b0) begin
          bp_bad++;
        end
        if (bp_left == 0) begin
          resp_ready_i = 1'b1;
          hs = 1;
        end else begin
          bp_left--;
        end
      end
    end
    brom_ready_i = 1'b1;
    brom_resp_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b0;
    brom_ready_i = 1'b1; brom_resp_data_i = '0; brom_resp_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid_o); end
    checks++; if (resp_error_o !== 1'b0) begin errors++; $display("FAIL reset_resp_error got %b exp 0", resp_error_o); end
    checks++; if (brom_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_brom_valid got %b exp 0", brom_req_valid_o); end
    checks++; if (brom_req_address_o !== 24'h0) begin errors++; $display("FAIL reset_brom_addr got %h exp 0", brom_req_address_o); end
    checks++; if (resp_line_o !== 128'h0) begin errors++; $display("FAIL reset_line got %h exp 0", resp_line_o); end
  endtask

  task automatic test_basic();
    run_line(24'h000100, 2, -1, 0, 0, 0, -1, 200);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", hs); end
    checks++; if (n_issue != 4) begin errors++; $display("FAIL basic_pulses got %0d exp 4", n_issue); end
    checks++; if ({issued[0], issued[1], issued[2], issued[3]} !== {24'h000100, 24'h000104, 24'h000108, 24'h00010C})
      begin errors++; $display("FAIL basic_addrs got %h %h %h %h exp 100 104 108 10c", issued[0], issued[1], issued[2], issued[3]); end
    checks++; if (lat != 13) begin errors++; $display("FAIL basic_latency got %0d exp 13", lat); end
    checks++; if (got_line !== 128'h0000010C_00000108_00000104_00000100)
      begin errors++; $display("FAIL basic_line got %h exp 0000010c000001080000010400000100", got_line); end
    checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL basic_error got %b exp 0", got_err); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", req_ready_o); end
  endtask

  task automatic test_unaligned();
    run_line(24'h00203C, 1, -1, 0, 0, 0, -1, 200);
    checks++; if (n_issue != 4) begin errors++; $display("FAIL unal_pulses got %0d exp 4", n_issue); end
    checks++; if (issued[0] !== 24'h002030) begin errors++; $display("FAIL unal_first got %h exp 002030", issued[0]); end
    checks++; if (issued[3] !== 24'h00203C) begin errors++; $display("FAIL unal_last got %h exp 00203c", issued[3]); end
    checks++; if (lat != 9) begin errors++; $display("FAIL unal_latency got %0d exp 9", lat); end
    checks++; if (got_line !== 128'h0000203C_00002038_00002034_00002030)
      begin errors++; $display("FAIL unal_line got %h exp 0000203c000020380000203400002030", got_line); end
  endtask

  task automatic test_ready_gating();
    run_line(24'h000480, 3, -1, 0, 1, 0, -1, 300);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL gate_done got %b exp 1", hs); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL gate_valid_while_busy got %0d exp 0", bad_valid); end
    checks++; if (n_issue != 4) begin errors++; $display("FAIL gate_pulses got %0d exp 4", n_issue); end
    checks++; if (got_line !== 128'h0000048C_00000488_00000484_00000480)
      begin errors++; $display("FAIL gate_line got %h exp 0000048c000004880000048400000480", got_line); end
  endtask

  task automatic test_backpressure();
    run_line(24'h000A00, 1, -1, 0, 0, 10, -1, 200);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", hs); end
    checks++; if (lat != 9) begin errors++; $display("FAIL bp_latency got %0d exp 9", lat); end
    checks++; if (bp_bad != 0) begin errors++; $display("FAIL bp_hold_violations got %0d exp 0", bp_bad); end
    checks++; if (got_line !== 128'h00000A0C_00000A08_00000A04_00000A00)
      begin errors++; $display("FAIL bp_line got %h exp 00000a0c00000a0800000a0400000a00", got_line); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", resp_valid_o); end
  endtask

  task automatic test_stray_idle();
    @(negedge clk);
    brom_resp_valid_i = 1'b1; brom_resp_data_i = 32'hDEADBEEF;
    @(negedge clk);
    brom_resp_valid_i = 1'b0;
    #1;
    checks++; if (resp_line_o !== 128'h00000A0C_00000A08_00000A04_00000A00)
      begin errors++; $display("FAIL stray_line got %h exp previous line", resp_line_o); end
    checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || brom_req_valid_o !== 1'b0)
      begin errors++; $display("FAIL stray_state got rdy=%b rv=%b bv=%b exp 1 0 0", req_ready_o, resp_valid_o, brom_req_valid_o); end
    run_line(24'h000040, 1, -1, 0, 0, 0, -1, 200);
    checks++; if (got_line !== 128'h0000004C_00000048_00000044_00000040)
      begin errors++; $display("FAIL stray_next_line got %h exp 0000004c000000480000004400000040", got_line); end
  endtask

  task automatic test_reset_mid();
    run_line(24'h000300, 2, -1, 0, 0, 0, 2, 200);
    checks++; if (n_issue != 3) begin errors++; $display("FAIL rstmid_issued got %0d exp 3", n_issue); end
    checks++; if (lat != -1) begin errors++; $display("FAIL rstmid_no_resp got %0d exp -1", lat); end
    brom_resp_valid_i = 1'b1; brom_resp_data_i = 32'h12345678;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready_o); end
    checks++; if ({resp_valid_o, resp_error_o, brom_req_valid_o} !== 3'b000)
      begin errors++; $display("FAIL rstmid_outs got %b exp 000", {resp_valid_o, resp_error_o, brom_req_valid_o}); end
    checks++; if (brom_req_address_o !== 24'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", brom_req_address_o); end
    @(negedge clk);
    brom_resp_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (resp_line_o !== 128'h0 || resp_valid_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_inflight got line=%h rv=%b exp 0 0", resp_line_o, resp_valid_o); end
  endtask

  task automatic test_timeout();
`ifdef BROM_FETCH_TIMEOUT_EN
    run_line(24'h000700, 2, 1, 70, 0, 10, -1, 300);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", hs); end
    checks++; if (n_issue != 2) begin errors++; $display("FAIL to_issued got %0d exp 2", n_issue); end
    checks++; if (lat != 69) begin errors++; $display("FAIL to_latency got %0d exp 69", lat); end
    checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL to_error got %b exp 1", got_err); end
    checks++; if (got_line !== 128'h0) begin errors++; $display("FAIL to_line got %h exp 0", got_line); end
    checks++; if (bp_bad != 0) begin errors++; $display("FAIL to_late_resp got %0d exp 0", bp_bad); end
    checks++; if (resp_error_o !== 1'b0) begin errors++; $display("FAIL to_error_after got %b exp 0", resp_error_o); end
    run_line(24'h000710, 1, -1, 0, 0, 0, -1, 200);
    checks++; if (got_err !== 1'b0 || got_line !== 128'h0000071C_00000718_00000714_00000710)
      begin errors++; $display("FAIL to_recover got err=%b line=%h exp 0 0000071c000007180000071400000710", got_err, got_line); end
`else
    run_line(24'h000700, 2, 1, 70, 0, 0, -1, 300);
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL slow_done got %b exp 1", hs); end
    checks++; if (lat != 81) begin errors++; $display("FAIL slow_latency got %0d exp 81", lat); end
    checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL slow_error got %b exp 0", got_err); end
    checks++; if (got_line !== 128'h0000070C_00000708_00000704_00000700)
      begin errors++; $display("FAIL slow_line got %h exp 0000070c000007080000070400000700", got_line); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unaligned();
    test_ready_gating();
    test_backpressure();
    test_stray_idle();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brom_line_fetch.md
Name: brom_line_fetch

Overview:
- Initiator side of the boot ROM word-read interface.
- Accepts a 128-bit line fetch request from the core front-end or instruction cache refill path.
- Issues four sequential 32-bit word reads to the boot ROM responder, one outstanding at a time, assembles the words into a line, and returns the line with a valid/ready handshake.
- Sits between the fetch unit and the boot ROM.

Parameters:
- ADDR_WIDTH, 24, byte address width of the boot ROM request bus.
- WORDS_PER_LINE, 4, 32-bit words per returned line; power of two.
- TIMEOUT_CYCLES, 64, watchdog limit per word; used only with BROM_FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid_i  in  1  line fetch request.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  ADDR_WIDTH  byte address; low 4 bits ignored.
- resp_valid_o  out  1  assembled line available.
- resp_ready_i  in  1  consumer accepts the line.
- resp_line_o  out  32*WORDS_PER_LINE  line; word i at bits [32i +: 32].
- resp_error_o  out  1  line aborted by watchdog; tied 0 when the feature is out.
- brom_req_valid_o  out  1  word read request to the boot ROM.
- brom_req_address_o  out  ADDR_WIDTH  word byte address.
- brom_ready_i  in  1  boot ROM idle.
- brom_resp_data_i  in  32  read data.
- brom_resp_valid_i  in  1  single-cycle response pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; word index = 0; line register = 0.
  - resp_valid_o = 0, resp_error_o = 0, brom_req_valid_o = 0, brom_req_address_o = 0.
  - req_ready_o = 1 from the first cycle after reset.
  - Reset mid-fetch abandons the fetch; nothing is returned.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: latch base = {req_addr_i[ADDR_WIDTH-1:4], 4'b0}, index = 0, clear the line register, go to ISSUE.
- ISSUE:
  - brom_req_valid_o = (state==ISSUE) & brom_ready_i, combinational.
  - The pulse lasts exactly one cycle per word. The boot ROM re-latches its address on any valid, so valid is never asserted while brom_ready_i = 0.
  - brom_req_address_o = base + 4*index, stable throughout ISSUE and WAIT_RESP.
  - Go to WAIT_RESP on the issue cycle.
- WAIT_RESP:
  - On brom_resp_valid_i: write brom_resp_data_i into word[index].
  - If index == WORDS_PER_LINE-1, go to RESP; otherwise increment index and go to ISSUE.
- RESP:
  - resp_valid_o = 1; resp_line_o and resp_error_o are held stable until resp_ready_i.
  - On resp_ready_i, go to IDLE. The next request can be accepted in the following cycle; there is no same-cycle turnaround.
- Stray responses: brom_resp_valid_i outside WAIT_RESP is ignored and leaves no state change. This covers late responses after a timeout and responses in flight across a reset.
- Latency: with brom_ready_i held at 1 and a responder latency of L cycles (from issue edge to response pulse), resp_valid_o rises 1 + 4*(L+1) cycles after the request acceptance edge.
- Address arithmetic: the index is log2(WORDS_PER_LINE) bits wide. Base plus offset never carries beyond bit 3.

Optional Feature:
- Macro BROM_FETCH_TIMEOUT_EN.
- Defined:
  - A per-word counter resets on entering WAIT_RESP and increments each WAIT_RESP cycle.
  - When it reaches TIMEOUT_CYCLES without a response: go to RESP with resp_error_o = 1 and resp_line_o = 0.
  - A response arriving in the same cycle as the limit wins; it is stored and the counter is ignored.
- Undefined: no counter; WAIT_RESP waits indefinitely; resp_error_o = 0.

Decomposition:
- Package brom_fetch_pkg holds:
  - state enum brom_fetch_state_t (IDLE, ISSUE, WAIT_RESP, RESP);
  - localparams BROM_WORD_BYTES = 4 and BROM_LINE_OFFSET = 4;
  - line typedef brom_line_t.
- Flat module; no sub-module warranted. The watchdog is a few lines under the macro.

Test Plan:
- Basic fetch:
  - Stimulus: req 0x000100; responder L=2, ready=1, data = address.
  - Required: brom addresses 0x000100, 0x000104, 0x000108, 0x00010C, one valid pulse each.
  - Required: resp_valid_o at acceptance+13; line = {0x10C, 0x108, 0x104, 0x100}.
- Unaligned request:
  - Stimulus: req 0x00203C.
  - Required: base 0x002030; issued addresses 0x002030 to 0x00203C.
- Ready gating:
  - Stimulus: brom_ready_i low for 7 cycles after each response.
  - Required: brom_req_valid_o never high while ready = 0; exactly 4 pulses per line; correct line.
- Backpressure:
  - Stimulus: resp_ready_i held low 10 cycles.
  - Required: resp_valid_o=1, line stable, req_ready_o=0, no brom requests.
  - Required: after the handshake, IDLE and req_ready_o=1 next cycle.
- Stray response and reset:
  - Stimulus: brom_resp_valid_i pulse in IDLE.
  - Required: no state or line change.
  - Stimulus: rst during WAIT_RESP of word 2.
  - Required: all outputs 0, req_ready_o=1 next cycle, no resp_valid_o.
- Timeout (macro defined, TIMEOUT_CYCLES=64):
  - Stimulus: responder drops word 1.
  - Required: resp_valid_o=1, resp_error_o=1, line=0 after 64 WAIT_RESP cycles; the late response is ignored.
